// File: rtl/accumulator_array.sv
// accumulator_array: deskews staggered MMU column outputs into a double-buffered
// accumulator memory with a per-buffer clear sequencer and a handshaked read port.
module accumulator_array #(
  parameter int N_COLS   = 4,
  parameter int IN_W     = 16,
  parameter int ACC_W    = 32,
  parameter int DEPTH    = 8,
  parameter int SATURATE = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic                    acc_mode,
  input  logic                    buf_sel,
  input  logic [AW-1:0]           wr_addr,
  input  logic [N_COLS*IN_W-1:0]  col_in,
  input  logic                    clr_start,
  input  logic                    clr_buf,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic                    rd_buf,
  input  logic [AW-1:0]           rd_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_COLS*ACC_W-1:0] out_data,
  output logic                    sat_flag,
  output logic                    drop_flag
);
  localparam int CW = 3 + AW;
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic {IDLE, CLEAR} state_t;
  logic [N_COLS*IN_W-1:0]  col_al;
  logic [CW-1:0]           ctl_q [N_COLS-1];
  logic [CW-1:0]           ctl_d [N_COLS-1];
  logic [N_COLS*ACC_W-1:0] mem_q [2*DEPTH];
  logic [N_COLS*ACC_W-1:0] mem_d [2*DEPTH];
  logic [N_COLS*ACC_W-1:0] wr_row, out_data_q, out_data_d;
  logic [ACC_W-1:0]        stored_v;
  logic [ACC_W:0]          sum_v;
  logic                    w_v, w_mode, w_buf, ovf, ovf_c, hit, rd_acc;
  logic [AW-1:0]           w_addr, cnt_q, cnt_d;
  state_t                  state_q, state_d;
  logic                    cbuf_q, cbuf_d, out_valid_q, out_valid_d;
  logic                    sat_q, sat_d, drop_q, drop_d;
  // column c needs N_COLS-1-c stages so every column lines up with the last one
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    localparam int D = N_COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign col_al[c*IN_W +: IN_W] = col_in[c*IN_W +: IN_W];
    end else begin : g_dly
      logic [IN_W-1:0] sr_q [D];
      logic [IN_W-1:0] sr_d [D];
      always_comb begin
        sr_d[0] = col_in[c*IN_W +: IN_W];
        for (int s = 1; s < D; s++) sr_d[s] = sr_q[s-1];
      end
      always_ff @(posedge clk or posedge reset)
        if (reset) sr_q <= '{default: '0};
        else sr_q <= sr_d;
      assign col_al[c*IN_W +: IN_W] = sr_q[D-1];
    end
  end
  always_comb begin
    ctl_d[0] = {valid_in, acc_mode, buf_sel, wr_addr};
    for (int s = 1; s < N_COLS - 1; s++) ctl_d[s] = ctl_q[s-1];
  end
  assign {w_v, w_mode, w_buf, w_addr} = ctl_q[N_COLS-2];
  assign busy = (state_q == CLEAR);
  assign hit  = busy && (w_buf == cbuf_q);
  always_comb begin
    ovf      = 1'b0;
    ovf_c    = 1'b0;
    stored_v = '0;
    sum_v    = '0;
    wr_row   = '0;
    for (int c = 0; c < N_COLS; c++) begin
      stored_v = w_mode ? mem_q[{w_buf, w_addr}][c*ACC_W +: ACC_W] : '0;
      sum_v = {stored_v[ACC_W-1], stored_v}
            + {{(ACC_W+1-IN_W){col_al[c*IN_W+IN_W-1]}}, col_al[c*IN_W +: IN_W]};
      ovf_c = sum_v[ACC_W] ^ sum_v[ACC_W-1];
      ovf = ovf | ovf_c;
      wr_row[c*ACC_W +: ACC_W] = (ovf_c && SATURATE != 0) ? (sum_v[ACC_W] ? MIN_V : MAX_V)
                                                          : sum_v[ACC_W-1:0];
    end
  end
  always_comb begin
    mem_d = mem_q;
    if (w_v && !hit) mem_d[{w_buf, w_addr}] = wr_row;
    if (busy) mem_d[{cbuf_q, cnt_q}] = '0;
    state_d     = busy ? ((cnt_q == AW'(DEPTH-1)) ? IDLE : CLEAR) : (clr_start ? CLEAR : IDLE);
    cnt_d       = busy ? cnt_q + 1'b1 : '0;
    cbuf_d      = (!busy && clr_start) ? clr_buf : cbuf_q;
    sat_d       = sat_q | (w_v && !hit && ovf);
    drop_d      = drop_q | (w_v && hit);
    rd_acc      = rd_en && (!out_valid_q || out_ready);
    out_valid_d = rd_acc || (out_valid_q && !out_ready);
    out_data_d  = rd_acc ? mem_q[{rd_buf, rd_addr}] : out_data_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctl_q       <= '{default: '0};
      mem_q       <= '{default: '0};
      state_q     <= IDLE;
      cnt_q       <= '0;
      cbuf_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      ctl_q       <= ctl_d;
      mem_q       <= mem_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cbuf_q      <= cbuf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
    end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;
endmodule

// File: tb/tb_accumulator_array.sv
// tb_accumulator_array: directed bench for accumulator_array; two narrow-accumulator
// copies (saturating and wrapping) share the stimulus so overflow is reachable quickly.
module tb_accumulator_array;
  localparam int N = 4, IW = 16, NW = 20;
  logic            clk = 1'b0, reset;
  logic            valid_in, acc_mode, buf_sel, clr_start, clr_buf, rd_en, rd_buf, out_ready;
  logic [2:0]      wr_addr, rd_addr;
  logic [N*IW-1:0] col_in;
  logic            busy, out_valid, sat_flag, drop_flag;
  logic [N*32-1:0] out_data;
  logic            s_busy, s_ov, s_sat, s_drop, w_busy, w_ov, w_sat, w_drop;
  logic [N*NW-1:0] s_data, w_data;
  logic [N*IW-1:0] hist [N];
  logic [N*IW-1:0] nxt_row;
  logic            nxt_v, nxt_mode, nxt_buf;
  logic [2:0]      nxt_addr;
  int              checks = 0, errors = 0, busy_n;

  accumulator_array u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .acc_mode(acc_mode), .buf_sel(buf_sel),
    .wr_addr(wr_addr), .col_in(col_in), .clr_start(clr_start), .clr_buf(clr_buf), .busy(busy),
    .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag), .drop_flag(drop_flag));
  accumulator_array #(.ACC_W(NW), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .valid_in(valid_in), .acc_mode(acc_mode), .buf_sel(buf_sel),
    .wr_addr(wr_addr), .col_in(col_in), .clr_start(clr_start), .clr_buf(clr_buf), .busy(s_busy),
    .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .out_valid(s_ov),
    .out_ready(out_ready), .out_data(s_data), .sat_flag(s_sat), .drop_flag(s_drop));
  accumulator_array #(.ACC_W(NW), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .valid_in(valid_in), .acc_mode(acc_mode), .buf_sel(buf_sel),
    .wr_addr(wr_addr), .col_in(col_in), .clr_start(clr_start), .clr_buf(clr_buf), .busy(w_busy),
    .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .out_valid(w_ov),
    .out_ready(out_ready), .out_data(w_data), .sat_flag(w_sat), .drop_flag(w_drop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [N*IW-1:0] r16(input int a3, input int a2, input int a1, input int a0);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [127:0] r32(input int a3, input int a2, input int a1, input int a0);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  // column c carries the row issued c cycles ago, mimicking the systolic skew
  task automatic tick();
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = nxt_row;
    for (int c = 0; c < N; c++) col_in[c*IW +: IW] = hist[c][c*IW +: IW];
    valid_in = nxt_v; acc_mode = nxt_mode; buf_sel = nxt_buf; wr_addr = nxt_addr;
    @(posedge clk); #1;
    nxt_v = 1'b0; nxt_row = '0; clr_start = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_wr(input logic m, input logic b, input logic [2:0] a, input logic [N*IW-1:0] row);
    nxt_v = 1'b1; nxt_mode = m; nxt_buf = b; nxt_addr = a; nxt_row = row;
  endtask

  task automatic wr(input logic m, input logic b, input logic [2:0] a, input logic [N*IW-1:0] row);
    set_wr(m, b, a, row);
    tick();
  endtask

  task automatic rd(input logic b, input logic [2:0] a);
    rd_en = 1'b1; rd_buf = b; rd_addr = a; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; valid_in = 0; acc_mode = 0; buf_sel = 0; wr_addr = '0; col_in = '0;
    clr_start = 0; clr_buf = 0; rd_en = 0; rd_buf = 0; rd_addr = '0; out_ready = 1'b1;
    nxt_v = 0; nxt_mode = 0; nxt_buf = 0; nxt_addr = '0; nxt_row = '0;
    foreach (hist[k]) hist[k] = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_drop", drop_flag, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    wr(0, 0, 2, r16(4, 3, 2, 1));
    idle(2);
    rd(0, 2);
    chk("s1_ov", out_valid, 1);
    chk("s1_prewrite", out_data, 0);
    rd(0, 2);
    chk("s1_row", out_data, r32(4, 3, 2, 1));
    idle(1);
    chk("s1_ov_drop", out_valid, 0);

    wr(1, 0, 2, r16(-10, 1, 1, 1));
    wr(1, 0, 2, r16(1, 1, 1, 1));
    idle(2);
    rd(0, 2);
    chk("s2_acc", out_data, r32(-6, 4, 3, 2));
    rd(0, 2);
    chk("s2_fwd", out_data, r32(-5, 5, 4, 3));
    idle(1);

    wr(0, 1, 5, r16(0, 0, -32768, 32767));
    repeat (15) wr(1, 1, 5, r16(0, 0, -32768, 32767));
    idle(3);
    chk("s3_sat_pre", s_sat, 0);
    chk("s3_wrap_pre", w_sat, 0);
    rd(1, 5);
    chk("s3_sat_edge", s_data, {20'h0, 20'h0, 20'h80000, 20'h7FFF0});
    chk("s3_main_edge", out_data, r32(0, 0, -524288, 524272));
    wr(1, 1, 5, r16(0, 5, -1, 32));
    idle(3);
    chk("s3_sat_flag", s_sat, 1);
    chk("s3_wrap_flag", w_sat, 1);
    chk("s3_main_flag", sat_flag, 0);
    rd(1, 5);
    chk("s3_sat_row", s_data, {20'h0, 20'h5, 20'h80000, 20'h7FFFF});
    chk("s3_wrap_row", w_data, {20'h0, 20'h5, 20'h7FFFF, 20'h80010});
    chk("s3_main_row", out_data, r32(0, 5, -524289, 524304));
    idle(1);

    for (int r = 0; r < 8; r++) wr(0, 1, 3'(r), r16(r + 1, r + 1, r + 1, r + 1));
    idle(3);
    chk("s4_busy_idle", busy, 0);
    chk("s4_drop_pre", drop_flag, 0);
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin clr_start = 1'b1; clr_buf = 1'b1; end
      if (i == 1) set_wr(0, 0, 6, r16(7, 7, 7, 7));
      if (i == 2) set_wr(0, 1, 0, r16(9, 9, 9, 9));
      if (i == 3) begin clr_start = 1'b1; clr_buf = 1'b0; end
      tick();
      busy_n += int'(busy);
    end
    chk("s4_busy_len", busy_n, 8);
    chk("s4_drop", drop_flag, 1);
    for (int r = 0; r < 8; r++) begin
      rd(1, 3'(r));
      chk($sformatf("s4_clr_row%0d", r), out_data, 0);
    end
    rd(0, 6);
    chk("s4_other_buf", out_data, r32(7, 7, 7, 7));
    rd(0, 2);
    chk("s4_buf0_kept", out_data, r32(-5, 5, 4, 3));
    idle(1);

    for (int r = 0; r < 4; r++) wr(0, 0, 3'(r), r16(10*r + 4, 10*r + 3, 10*r + 2, 10*r + 1));
    idle(3);
    for (int t = 0; t < 7; t++) begin
      rd_en = 1'b1; rd_buf = 1'b0;
      rd_addr = (t < 4) ? ((t == 0) ? 3'd0 : 3'd1) : 3'(t - 3);
      out_ready = (t >= 4);
      tick();
      chk($sformatf("s5_ov%0d", t), out_valid, 1);
      chk($sformatf("s5_data%0d", t), out_data,
          r32(10*((t < 4) ? 0 : t - 3) + 4, 10*((t < 4) ? 0 : t - 3) + 3,
              10*((t < 4) ? 0 : t - 3) + 2, 10*((t < 4) ? 0 : t - 3) + 1));
    end
    out_ready = 1'b1;
    tick();
    chk("s5_drain", out_valid, 0);

    clr_start = 1'b1; clr_buf = 1'b0;
    set_wr(0, 1, 3, r16(5, 5, 5, 5));
    tick();
    rd_en = 1'b1; rd_buf = 1'b0; rd_addr = 3'd6; out_ready = 1'b0;
    tick();
    chk("s6_busy_pre", busy, 1);
    chk("s6_ov_pre", out_valid, 1);
    reset = 1'b1;
    #2;
    chk("s6_busy", busy, 0);
    chk("s6_ov", out_valid, 0);
    chk("s6_data", out_data, 0);
    chk("s6_sat", s_sat, 0);
    chk("s6_drop", drop_flag, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    rd(1, 3);
    chk("s6_inflight", out_data, 0);
    rd(0, 6);
    chk("s6_row6", out_data, 0);
    rd(0, 2);
    chk("s6_row2", out_data, 0);
    rd(1, 5);
    chk("s6_sat_row", s_data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
